// File: rtl/obj_line_walker_if.sv
// Bus bundle between the OBJ line walker, the OBJ address unit, VRAM and the line buffer.
// The master side is the walker.
interface obj_line_walker_if;
  logic [5:0]  addr_x;
  logic [5:0]  addr_y;
  logic [6:0]  addr_hsize;
  logic [14:0] addr_in;
  logic        vram_req;
  logic [14:0] vram_addr;
  logic        vram_ack;
  logic [15:0] vram_data;
  logic        lb_we;
  logic [7:0]  lb_x;
  logic [7:0]  lb_index;

  modport master (
    output addr_x, addr_y, addr_hsize, vram_req, vram_addr, lb_we, lb_x, lb_index,
    input  addr_in, vram_ack, vram_data
  );
  modport slave (
    input  addr_x, addr_y, addr_hsize, vram_req, vram_addr, lb_we, lb_x, lb_index,
    output addr_in, vram_ack, vram_data
  );
endinterface

// File: rtl/obj_line_walker.sv
// Per-scanline OBJ pixel sequencer: walks one sprite row, fetches VRAM halfwords
// through a one-entry cache and writes opaque on-screen pixels to the line buffer.
module obj_line_walker #(
  parameter int SCREEN_W = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [8:0]  obj_x,
  input  logic [6:0]  obj_width,
  input  logic [6:0]  obj_height,
  input  logic [5:0]  row,
  input  logic        hflip,
  input  logic        vflip,
  input  logic        palette_mode,
  input  logic [3:0]  palbank,
  obj_line_walker_if.master bus,
  output logic        busy,
  output logic        done
);
  localparam logic [8:0] SW = 9'(SCREEN_W);

  typedef enum logic [2:0] {IDLE, FETCH, REQ, WRITE, DONE} state_t;
  state_t state, state_nx;

  logic [8:0]  ox;
  logic [6:0]  w;
  logic [5:0]  h_m1, r;
  logic        hf, vf, mode;
  logic [3:0]  pb;
  logic [5:0]  col;
  logic        cache_vld, abort_done;
  logic [14:0] cache_addr, vaddr;
  logic [15:0] cache_data;

  logic [5:0] w_m1, ax, ay;
  logic [8:0] sx;
  logic       visible, last, hit, opaque;
  logic [3:0] nib;
  logic [7:0] pix_byte, index;

  always_comb begin
    w_m1     = 6'(w - 7'd1);
    ax       = hf ? (w_m1 - col) : col;
    ay       = vf ? (h_m1 - r) : r;
    sx       = ox + {3'b0, col};
    visible  = sx < SW;
    last     = col == w_m1;
    hit      = cache_vld && (cache_addr == bus.addr_in);
    nib      = cache_data[{ax[1:0], 2'b00} +: 4];
    pix_byte = cache_data[{ax[0], 3'b000} +: 8];
    index    = mode ? pix_byte : {pb, nib};
    opaque   = mode ? |pix_byte : |nib;
  end

  assign bus.addr_x     = ax;
  assign bus.addr_y     = ay;
  assign bus.addr_hsize = {3'b0, w[6:3]};
  assign bus.vram_addr  = vaddr;
  // req drops in the abort cycle itself so the memory side sees no stale request
  assign bus.vram_req   = (state == REQ) && !abort;
  assign bus.lb_we      = (state == WRITE) && opaque;
  assign bus.lb_x       = sx[7:0];
  assign bus.lb_index   = index;
  assign busy           = state != IDLE;
  assign done           = (state == DONE) || abort_done;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = FETCH;
      FETCH: if (!visible) state_nx = last ? DONE : FETCH;
             else state_nx = hit ? WRITE : REQ;
      REQ:   if (bus.vram_ack) state_nx = WRITE;
      WRITE: state_nx = last ? DONE : FETCH;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ox         <= '0;
      w          <= '0;
      h_m1       <= '0;
      r          <= '0;
      hf         <= 1'b0;
      vf         <= 1'b0;
      mode       <= 1'b0;
      pb         <= '0;
      col        <= '0;
      cache_vld  <= 1'b0;
      cache_addr <= '0;
      cache_data <= '0;
      vaddr      <= '0;
      abort_done <= 1'b0;
    end else begin
      state      <= state_nx;
      abort_done <= abort && (state != IDLE) && (state != DONE);
      if (state == IDLE && start && !abort) begin
        ox        <= obj_x;
        w         <= obj_width;
        h_m1      <= 6'(obj_height - 7'd1);
        r         <= row;
        hf        <= hflip;
        vf        <= vflip;
        mode      <= palette_mode;
        pb        <= palbank;
        col       <= '0;
        cache_vld <= 1'b0;
      end
      if (!abort && !last && (state == WRITE || (state == FETCH && !visible)))
        col <= col + 6'd1;
      if (!abort && state == FETCH && visible && !hit)
        vaddr <= bus.addr_in;
      if (!abort && state == REQ && bus.vram_ack) begin
        cache_data <= bus.vram_data;
        cache_addr <= vaddr;
        cache_vld  <= 1'b1;
      end
    end
  end
endmodule
